io_input_ctrl: RTL and testbench
================================

Name: io_input_ctrl

Overview:
- Sequences the CPU's 9-bit input port: {ready, data[7:0]}.
- Replaces the raw ready switch with a sanitised handshake:
  - synchronises and debounces the ready switch;
  - latches the 8-bit data byte on a confirmed press;
  - holds ready until the CPU consumes the byte or a timeout expires;
  - re-arms only after the switch is released.
- Sits between the board switches and the CPU, in the full-speed clock domain.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (min 1).
- HOLD_CYCLES, 1024, max cycles in_ready stays high without ack before the byte is dropped (0 = no timeout).
- CNT_W, 16, width of the internal debounce/hold counters (must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_ready  input  1  raw ready switch (asynchronous)
- sw_data  input  8  raw data switches, sampled only at latch time
- ack  input  1  single-cycle pulse: CPU has consumed in_data
- in_ready  output  1  byte valid to CPU
- in_data  output  8  latched byte
- busy  output  1  high in every state except IDLE
- xfer_count  output  8  number of acked bytes, wraps 255->0
- dropped  output  1  sticky: a byte timed out unacked

Behaviour:
- Reset (async, active high) sets:
  - state=IDLE, in_ready=0, in_data=0x00, busy=0, xfer_count=0, dropped=0;
  - counters=0, synchroniser flops=0.
- Synchroniser: 2 flops on sw_ready → s_rdy. Data is not synchronised; it is sampled at latch, when the operator has already settled it.
- States: IDLE, DB_PRESS, PRESENT, WAIT_REL, DB_REL.
- IDLE:
  - s_rdy=1 → DB_PRESS, cnt=1.
- DB_PRESS:
  - s_rdy=0 → IDLE.
  - cnt reaches DEBOUNCE_CYCLES while s_rdy=1 → PRESENT, in_data<=sw_data, in_ready<=1, cnt=0.
  - Otherwise cnt++.
- PRESENT (in_ready=1):
  - ack=1 → in_ready<=0, xfer_count++, → WAIT_REL.
  - Else if HOLD_CYCLES≠0 and cnt=HOLD_CYCLES-1 → in_ready<=0, dropped<=1, → WAIT_REL.
  - Otherwise cnt++.
  - in_data is held constant throughout PRESENT.
  - Switch release during PRESENT does not withdraw ready.
- WAIT_REL:
  - s_rdy=0 → DB_REL, cnt=1.
- DB_REL:
  - s_rdy=1 → WAIT_REL.
  - cnt reaches DEBOUNCE_CYCLES while s_rdy=0 → IDLE.
  - Otherwise cnt++.
- Latency: s_rdy rising to in_ready=1 is DEBOUNCE_CYCLES cycles, plus 2 cycles of synchroniser latency from sw_ready.
- ack handling:
  - ack outside PRESENT is ignored: no count change, no error.
  - ack on the same cycle the timeout would fire: ack wins, counted, dropped unchanged.
- in_data keeps its last value after in_ready falls, until the next latch.
- No auto-repeat: holding the switch yields exactly one byte.
- Bounce shorter than DEBOUNCE_CYCLES, in either direction, produces no transition.
- Reset asserted mid-operation, in any state: immediate return to reset values; a pending byte is lost and not counted as dropped.
- dropped clears only on reset.
- xfer_count is modulo 256.

Test Plan:
- DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, sw_data=0xA5, sw_ready 0→1 held → in_ready=1, in_data=0xA5 exactly 6 cycles after sw_ready edge; ack pulse → in_ready=0 next cycle, xfer_count=1.
- sw_ready glitches high 3 cycles then low (DEBOUNCE_CYCLES=4) → in_ready never asserts, busy returns 0, xfer_count unchanged.
- Press latched with 0x3C, no ack for 20 cycles → in_ready falls on cycle 20, dropped=1, xfer_count=0; sw_data change to 0xFF during PRESENT leaves in_data=0x3C.
- Switch held 200 cycles with ack after 5 → one transfer only; release debounced then second press with 0x11 → second byte 0x11, xfer_count=2.
- Ack coincident with the timeout cycle → xfer_count increments, dropped stays 0; ack pulses in IDLE/WAIT_REL → no effect.
- Assert reset during PRESENT → in_ready=0, in_data=0x00, xfer_count=0, dropped=0 asynchronously; 256 acked transfers → xfer_count wraps to 0.

Source files
------------

// File: rtl/io_input_ctrl.sv
// Input-port sequencer: debounced ready switch, byte latch and
// ack/timeout handshake toward the CPU.
module io_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1024,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_ready,
  input  logic [7:0] sw_data,
  input  logic       ack,
  output logic       in_ready,
  output logic [7:0] in_data,
  output logic       busy,
  output logic [7:0] xfer_count,
  output logic       dropped
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESENT,
    WAIT_REL,
    DB_REL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic HOLD_EN = (HOLD_CYCLES != 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rdy_n;
  logic [7:0]       data_n;
  logic [7:0]       xfer_n;
  logic             drop_n;
  logic             sync1, s_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s_rdy <= 1'b0;
    end else begin
      sync1 <= sw_ready;
      s_rdy <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      in_data    <= 8'h00;
      xfer_count <= 8'h00;
      dropped    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      in_ready   <= rdy_n;
      in_data    <= data_n;
      xfer_count <= xfer_n;
      dropped    <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdy_n   = in_ready;
    data_n  = in_data;
    xfer_n  = xfer_count;
    drop_n  = dropped;
    unique case (state)
      IDLE: begin
        if (s_rdy) begin
          state_n = DB_PRESS;
          cnt_n   = CNT_W'(1);
        end
      end
      DB_PRESS: begin
        if (!s_rdy) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= DB_LAST) begin
          state_n = PRESENT;
          data_n  = sw_data;
          rdy_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESENT: begin
        // ack takes priority over a timeout landing on the same cycle
        if (ack) begin
          state_n = WAIT_REL;
          rdy_n   = 1'b0;
          xfer_n  = xfer_count + 8'd1;
          cnt_n   = '0;
        end else if (HOLD_EN && cnt == HOLD_LAST) begin
          state_n = WAIT_REL;
          rdy_n   = 1'b0;
          drop_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!s_rdy) begin
          state_n = DB_REL;
          cnt_n   = CNT_W'(1);
        end
      end
      DB_REL: begin
        if (s_rdy) begin
          state_n = WAIT_REL;
          cnt_n   = '0;
        end else if (cnt >= DB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus random switch
// activity, checked every cycle against a run-length reference model.
module tb_io_input_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_ready;
  logic [7:0] sw_data;
  logic       ack;
  logic       in_ready;
  logic [7:0] in_data;
  logic       busy;
  logic [7:0] xfer_count;
  logic       dropped;

  int tests = 0;
  int fails = 0;

  io_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_ready(sw_ready),
    .sw_data(sw_data),
    .ack(ack),
    .in_ready(in_ready),
    .in_data(in_data),
    .busy(busy),
    .xfer_count(xfer_count),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  // model: 0 = armed (waiting for press), 1 = presenting, 2 = awaiting release
  int         mode;
  int         hi_run, lo_run, held;
  logic       m_s1, m_s2;
  logic       m_rdy, m_drop;
  logic [7:0] m_data, m_xfer;

  task automatic model_reset();
    mode   = 0;
    hi_run = 0;
    lo_run = 0;
    held   = 0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_rdy  = 1'b0;
    m_drop = 1'b0;
    m_data = 8'h00;
    m_xfer = 8'h00;
  endtask

  task automatic model_edge();
    logic s;
    if (reset) begin
      model_reset();
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = sw_ready;
    if (mode == 0) begin
      hi_run = s ? hi_run + 1 : 0;
      if (hi_run >= DEB) begin
        mode   = 1;
        m_rdy  = 1'b1;
        m_data = sw_data;
        held   = 0;
        hi_run = 0;
      end
    end else if (mode == 1) begin
      held++;
      if (ack) begin
        m_rdy  = 1'b0;
        m_xfer = m_xfer + 8'd1;
        mode   = 2;
        lo_run = 0;
      end else if (HOLD != 0 && held == HOLD) begin
        m_rdy  = 1'b0;
        m_drop = 1'b1;
        mode   = 2;
        lo_run = 0;
      end
    end else begin
      lo_run = s ? 0 : lo_run + 1;
      if (lo_run >= DEB) begin
        mode   = 0;
        hi_run = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic mb;
    mb = !(mode == 0 && hi_run == 0);
    check("in_ready", {7'b0, in_ready}, {7'b0, m_rdy});
    check("in_data", in_data, m_data);
    check("busy", {7'b0, busy}, {7'b0, mb});
    check("xfer_count", xfer_count, m_xfer);
    check("dropped", {7'b0, dropped}, {7'b0, m_drop});
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    sw_ready = 1'b0;
    sw_data  = 8'h00;
    ack      = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", {7'b0, in_ready}, 8'h00);
    check("rst_in_data", in_data, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_xfer", xfer_count, 8'h00);
    check("rst_dropped", {7'b0, dropped}, 8'h00);
    @(negedge clk);
    do_reset();

    // press with 0xA5: ready exactly 6 cycles after the switch edge
    sw_data  = 8'hA5;
    sw_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("lat_early", {7'b0, in_ready}, 8'h00);
    end
    tick();
    check("lat_ready", {7'b0, in_ready}, 8'h01);
    check("lat_data", in_data, 8'hA5);
    pulse_ack();
    check("ack_ready", {7'b0, in_ready}, 8'h00);
    check("ack_xfer", xfer_count, 8'h01);
    sw_ready = 1'b0;
    tick(10);

    // 3-cycle glitch must be rejected
    sw_ready = 1'b1;
    tick(3);
    sw_ready = 1'b0;
    tick(8);
    check("glitch_busy", {7'b0, busy}, 8'h00);
    check("glitch_xfer", xfer_count, 8'h01);

    // timeout with data change during PRESENT
    do_reset();
    sw_data  = 8'h3C;
    sw_ready = 1'b1;
    tick(6);
    sw_data = 8'hFF;
    tick(19);
    check("to_hold", {7'b0, in_ready}, 8'h01);
    tick();
    check("to_ready", {7'b0, in_ready}, 8'h00);
    check("to_dropped", {7'b0, dropped}, 8'h01);
    check("to_xfer", xfer_count, 8'h00);
    check("to_data", in_data, 8'h3C);
    sw_ready = 1'b0;
    tick(10);

    // long hold yields one byte; second press after release
    sw_data  = 8'h5A;
    sw_ready = 1'b1;
    tick(10);
    pulse_ack();
    tick(190);
    check("hold_xfer", xfer_count, 8'h01);
    check("hold_ready", {7'b0, in_ready}, 8'h00);
    sw_ready = 1'b0;
    tick(10);
    sw_data  = 8'h11;
    sw_ready = 1'b1;
    tick(6);
    check("second_data", in_data, 8'h11);
    pulse_ack();
    check("second_xfer", xfer_count, 8'h02);

    // ack coincident with timeout; stray acks in WAIT_REL and IDLE
    do_reset();
    sw_ready = 1'b0;
    tick(3);
    sw_ready = 1'b1;
    tick(6);
    tick(19);
    pulse_ack();
    check("coin_xfer", xfer_count, 8'h01);
    check("coin_dropped", {7'b0, dropped}, 8'h00);
    pulse_ack();
    check("stray_wait", xfer_count, 8'h01);
    sw_ready = 1'b0;
    tick(10);
    pulse_ack();
    check("stray_idle", xfer_count, 8'h01);

    // async reset during PRESENT
    sw_data  = 8'h77;
    sw_ready = 1'b1;
    tick(6);
    check("pre_rst_ready", {7'b0, in_ready}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", {7'b0, in_ready}, 8'h00);
    check("arst_data", in_data, 8'h00);
    check("arst_xfer", xfer_count, 8'h00);
    check("arst_dropped", {7'b0, dropped}, 8'h00);
    model_reset();
    sw_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // 256 acked transfers wrap the counter
    for (int n = 0; n < 256; n++) begin
      sw_data  = 8'(n);
      sw_ready = 1'b1;
      tick(6);
      pulse_ack();
      sw_ready = 1'b0;
      tick(10);
    end
    check("wrap_xfer", xfer_count, 8'h00);
    check("wrap_dropped", {7'b0, dropped}, 8'h00);

    // random switch activity against the model
    for (int r = 0; r < 300; r++) begin
      int len;
      sw_ready = 1'($urandom_range(0, 1));
      len      = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        sw_data = 8'($urandom);
        ack     = ($urandom_range(0, 7) == 0);
        tick();
      end
      ack = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
